// File: rtl/tx_cu.sv
// USB full-speed transmit control unit: sequences SYNC, PID, payload, CRC16 and EOP
// through the byte serializer, draining the TX FIFO for data packets.
module tx_cu (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] buffer_occupancy,
  input  logic       byte_done,
  input  logic       eop_done,
  output logic [7:0] tx_byte,
  output logic       load_byte,
  output logic       get_tx_packet_data,
  output logic       send_eop,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] SYNC        = 4'd1;
  localparam logic [3:0] SYNC_WAIT   = 4'd2;
  localparam logic [3:0] PID         = 4'd3;
  localparam logic [3:0] PID_WAIT    = 4'd4;
  localparam logic [3:0] DATA        = 4'd5;
  localparam logic [3:0] DATA_WAIT   = 4'd6;
  localparam logic [3:0] CRC_LO      = 4'd7;
  localparam logic [3:0] CRC_LO_WAIT = 4'd8;
  localparam logic [3:0] CRC_HI      = 4'd9;
  localparam logic [3:0] CRC_HI_WAIT = 4'd10;
  localparam logic [3:0] EOP         = 4'd11;
  localparam logic [3:0] EOP_WAIT    = 4'd12;

  localparam logic [7:0] SYNC_BYTE = 8'h01;

  logic [3:0]  state, next_state;
  logic [2:0]  cmd;
  logic [6:0]  remaining;
  logic [15:0] crc;
  logic        req_is_data, req_valid, req_bad, cmd_is_data;
  logic [7:0]  pid_byte;

  // Reflected USB CRC16 (poly 0x8005 bit-reversed), data bits LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    req_is_data = (tx_packet == 4'd1) || (tx_packet == 4'd2);
    req_valid   = (tx_packet >= 4'd1) && (tx_packet <= 4'd5) &&
                  !(req_is_data && (buffer_occupancy > 7'd64));
    req_bad     = (tx_packet >= 4'd6) || (req_is_data && (buffer_occupancy > 7'd64));
    cmd_is_data = (cmd == 3'd1) || (cmd == 3'd2);
  end

  always_comb begin
    case (cmd)
      3'd1:    pid_byte = 8'hC3;
      3'd2:    pid_byte = 8'h4B;
      3'd3:    pid_byte = 8'hD2;
      3'd4:    pid_byte = 8'h5A;
      3'd5:    pid_byte = 8'h1E;
      default: pid_byte = 8'h00;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (req_valid) next_state = SYNC;
      SYNC:        next_state = SYNC_WAIT;
      SYNC_WAIT:   if (byte_done) next_state = PID;
      PID:         next_state = PID_WAIT;
      PID_WAIT:
        if (byte_done) begin
          if (!cmd_is_data)          next_state = EOP;
          else if (remaining != '0)  next_state = DATA;
          else                       next_state = CRC_LO;
        end
      DATA:        next_state = DATA_WAIT;
      DATA_WAIT:
        if (byte_done) next_state = (remaining != '0) ? DATA : CRC_LO;
      CRC_LO:      next_state = CRC_LO_WAIT;
      CRC_LO_WAIT: if (byte_done) next_state = CRC_HI;
      CRC_HI:      next_state = CRC_HI_WAIT;
      CRC_HI_WAIT: if (byte_done) next_state = EOP;
      EOP:         next_state = EOP_WAIT;
      EOP_WAIT:    if (eop_done) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Strobes and tx_byte are registered off next_state so they line up with the load state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= IDLE;
      cmd                <= '0;
      remaining          <= '0;
      crc                <= '1;
      tx_byte            <= '0;
      load_byte          <= 1'b0;
      get_tx_packet_data <= 1'b0;
      send_eop           <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      state              <= next_state;
      load_byte          <= (next_state == SYNC) || (next_state == PID) || (next_state == DATA) ||
                            (next_state == CRC_LO) || (next_state == CRC_HI);
      get_tx_packet_data <= (next_state == DATA);
      send_eop           <= (next_state == EOP);

      case (next_state)
        SYNC:    tx_byte <= SYNC_BYTE;
        PID:     tx_byte <= pid_byte;
        DATA:    tx_byte <= tx_packet_data;
        CRC_LO:  tx_byte <= ~crc[7:0];
        CRC_HI:  tx_byte <= ~crc[15:8];
        default: tx_byte <= tx_byte;
      endcase

      if (state == IDLE) begin
        if (req_valid) begin
          cmd                <= tx_packet[2:0];
          remaining          <= buffer_occupancy;
          crc                <= '1;
          tx_error           <= 1'b0;
          tx_transfer_active <= 1'b1;
        end else if (req_bad) begin
          tx_error <= 1'b1;
        end
      end

      if (state == DATA) begin
        crc       <= crc16_byte(crc, tx_byte);
        remaining <= remaining - 7'd1;
      end

      if ((state == EOP_WAIT) && eop_done) tx_transfer_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_cu.sv
// Bench for tx_cu: FIFO and serializer/encoder models with random latency, and a
// packet-level reference built from PID table plus an MSB-first CRC16 model.
module tb_tx_cu;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] tx_packet = '0;
  logic [7:0] tx_packet_data = '0;
  logic [6:0] buffer_occupancy = '0;
  logic       byte_done = 1'b0;
  logic       eop_done = 1'b0;
  logic [7:0] tx_byte;
  logic       load_byte, get_tx_packet_data, send_eop, tx_transfer_active, tx_error;

  tx_cu dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .byte_done          (byte_done),
    .eop_done           (eop_done),
    .tx_byte            (tx_byte),
    .load_byte          (load_byte),
    .get_tx_packet_data (get_tx_packet_data),
    .send_eop           (send_eop),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pkt_data[$];
  int loads = 0, pops = 0, eops = 0, bad_pop = 0, lat_err = 0;
  int occ_ovr = -1;
  int fixed_delay = 0;

  int  cnt = 0;
  bit  busy = 0, is_eop = 0, prev_bd = 0, prev_ed = 0;

  // Observation plus serializer/encoder responder, all on the falling edge.
  always @(negedge clk) begin
    if (!n_rst) begin
      busy = 0; cnt = 0; byte_done = 1'b0; eop_done = 1'b0; prev_bd = 0; prev_ed = 0;
    end else begin
      if (prev_bd && !(load_byte || send_eop)) lat_err++;
      if (prev_ed && tx_transfer_active) lat_err++;
      if (load_byte) begin got_q.push_back(tx_byte); loads++; end
      if (get_tx_packet_data) begin
        pops++;
        if (!load_byte) bad_pop++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (send_eop) eops++;
      byte_done = 1'b0;
      eop_done  = 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          if (is_eop) eop_done = 1'b1; else byte_done = 1'b1;
          busy = 0;
        end else cnt--;
      end
      if (load_byte || send_eop) begin
        busy   = 1;
        is_eop = send_eop;
        cnt    = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 8));
      end
      prev_bd = byte_done;
      prev_ed = eop_done;
    end
    tx_packet_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    buffer_occupancy = (occ_ovr >= 0) ? 7'(occ_ovr) : 7'(fifo_q.size());
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // USB CRC16 in non-reflected form; result bit-reversed and complemented for the wire.
  function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
    logic [15:0] c, r;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ d[k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15 - i];
    return ~r;
  endfunction

  function automatic logic [7:0] pid_of(input logic [3:0] c);
    case (c)
      4'd1: return 8'hC3;
      4'd2: return 8'h4B;
      4'd3: return 8'hD2;
      4'd4: return 8'h5A;
      4'd5: return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clear_counts();
    got_q.delete();
    loads = 0; pops = 0; eops = 0; bad_pop = 0; lat_err = 0;
  endtask

  task automatic send_cmd(input logic [3:0] c);
    @(negedge clk);
    tx_packet = c;
    @(negedge clk);
    tx_packet = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((eops == 0 || tx_transfer_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic run_packet(input string tag, input logic [3:0] c, input bit nak_mid);
    logic [7:0]  exp_q[$];
    logic [15:0] crc;
    bit          is_data;
    is_data = (c == 4'd1) || (c == 4'd2);
    fifo_q = pkt_data;
    clear_counts();
    exp_q.push_back(8'h01);
    exp_q.push_back(pid_of(c));
    if (is_data) begin
      foreach (pkt_data[k]) exp_q.push_back(pkt_data[k]);
      crc = crc_model(pkt_data);
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    send_cmd(c);
    chk({tag, "_active"}, 32'(tx_transfer_active), 32'd1);
    if (nak_mid) begin
      repeat (40) @(negedge clk);
      tx_packet = 4'd4;
      @(negedge clk);
      tx_packet = '0;
    end
    wait_idle(tag);
    chk({tag, "_loads"}, 32'(loads), 32'(exp_q.size()));
    chk({tag, "_pops"}, 32'(pops), is_data ? 32'(pkt_data.size()) : 32'd0);
    chk({tag, "_eops"}, 32'(eops), 32'd1);
    chk({tag, "_pop_with_load"}, 32'(bad_pop), 32'd0);
    chk({tag, "_latency"}, 32'(lat_err), 32'd0);
    chk({tag, "_error_flag"}, 32'(tx_error), 32'd0);
    foreach (exp_q[k])
      chk($sformatf("%s_byte%0d", tag, k), (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD, 32'(exp_q[k]));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [3:0] rc;
    int rl;

    repeat (3) @(negedge clk);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_load", 32'(load_byte), 32'd0);
    chk("rst_get", 32'(get_tx_packet_data), 32'd0);
    chk("rst_eop", 32'(send_eop), 32'd0);
    chk("rst_active", 32'(tx_transfer_active), 32'd0);
    chk("rst_error", 32'(tx_error), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    fixed_delay = 8;
    pkt_data.delete();
    run_packet("ack", 4'd3, 1'b0);
    fixed_delay = 0;

    pkt_data.delete();
    run_packet("zlp_data1", 4'd2, 1'b0);

    pkt_data = '{8'hFF, 8'hAA};
    run_packet("data0_ffaa", 4'd1, 1'b0);

    pkt_data.delete();
    for (int i = 0; i < 64; i++) pkt_data.push_back(8'(i));
    run_packet("data0_full", 4'd1, 1'b1);

    for (int t = 0; t < 3; t++) begin
      rc = 4'($urandom_range(1, 5));
      rl = int'($urandom_range(0, 64));
      pkt_data.delete();
      for (int i = 0; i < rl; i++) pkt_data.push_back(8'($urandom));
      run_packet($sformatf("rand%0d", t), rc, 1'b0);
    end

    clear_counts();
    send_cmd(4'd9);
    chk("bad9_error", 32'(tx_error), 32'd1);
    repeat (5) @(negedge clk);
    chk("bad9_loads", 32'(loads), 32'd0);
    chk("bad9_active", 32'(tx_transfer_active), 32'd0);

    pkt_data.delete();
    run_packet("nak_clear", 4'd4, 1'b0);

    clear_counts();
    fifo_q.delete();
    occ_ovr = 65;
    send_cmd(4'd1);
    chk("over65_error", 32'(tx_error), 32'd1);
    repeat (5) @(negedge clk);
    chk("over65_loads", 32'(loads), 32'd0);
    chk("over65_pops", 32'(pops), 32'd0);
    occ_ovr = -1;
    pkt_data.delete();
    run_packet("nak_clear2", 4'd4, 1'b0);

    fixed_delay = 8;
    pkt_data.delete();
    for (int i = 0; i < 10; i++) pkt_data.push_back(8'h80 + 8'(i));
    fifo_q = pkt_data;
    clear_counts();
    send_cmd(4'd1);
    n = 0;
    while (pops < 3 && n < 500) begin @(negedge clk); n++; end
    chk("midrst_reach_timeout", 32'(n < 500), 32'd1);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_tx_byte", 32'(tx_byte), 32'h00);
    chk("midrst_load", 32'(load_byte), 32'd0);
    chk("midrst_get", 32'(get_tx_packet_data), 32'd0);
    chk("midrst_eop", 32'(send_eop), 32'd0);
    chk("midrst_active", 32'(tx_transfer_active), 32'd0);
    chk("midrst_error", 32'(tx_error), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_pops_after", 32'(pops), 32'd3);
    chk("midrst_no_eop", 32'(eops), 32'd0);
    pkt_data.delete();
    run_packet("ack_after_rst", 4'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_cu.md
# tx_cu

USB full-speed transmit control unit, the counterpart of the receive control unit. On a one-cycle packet command from the endpoint side it sequences a packet through the byte-wide serializer/encoder: SYNC, PID, payload bytes drained from the TX FIFO, CRC16 for data packets, then an EOP request. It sits between the TX data buffer and the transmit shift register/NRZI encoder, and reports transfer activity and command errors upward.

## Interface
- No parameters. Max payload is fixed at 64 bytes.
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- tx_packet  in  4  command pulse: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 6–15 invalid
- tx_packet_data  in  8  TX FIFO head byte, valid whenever buffer_occupancy != 0
- buffer_occupancy  in  7  TX FIFO byte count
- byte_done  in  1  serializer pulse: the last loaded byte has been fully shifted out
- eop_done  in  1  encoder pulse: EOP complete, line idle
- tx_byte  out  8  byte to serializer, registered, held between loads
- load_byte  out  1  one-cycle pulse, tx_byte valid this cycle
- get_tx_packet_data  out  1  one-cycle FIFO pop
- send_eop  out  1  one-cycle EOP request
- tx_transfer_active  out  1  high from command accept through eop_done
- tx_error  out  1  sticky command-error flag

## Operation
- Byte values on tx_byte use the shared byte-bus convention: SYNC 8'h01, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
- States: IDLE, SYNC, SYNC_WAIT, PID, PID_WAIT, DATA, DATA_WAIT, CRC_LO, CRC_LO_WAIT, CRC_HI, CRC_HI_WAIT, EOP, EOP_WAIT.
  - Each non-WAIT state lasts 1 cycle and pulses load_byte (or send_eop in EOP).
  - Each WAIT state holds until byte_done (or eop_done).
- IDLE:
  - tx_packet in 1..5: latch the command, latch length = buffer_occupancy, go to SYNC, and clear tx_error.
  - tx_packet in 6..15, or a data command with buffer_occupancy > 64: set tx_error, stay in IDLE, emit no bytes.
  - tx_packet = 0: stay in IDLE.
- Transitions after PID_WAIT:
  - Handshake commands (ACK/NAK/STALL) go to EOP.
  - Data commands go to DATA if the latched length is greater than 0, otherwise to CRC_LO.
- DATA:
  - Drive tx_byte = tx_packet_data and pulse load_byte and get_tx_packet_data together.
  - Fold the byte into the CRC and decrement the remaining count.
  - DATA_WAIT goes to DATA while the remaining count is greater than 0, otherwise to CRC_LO.
- CRC16 (USB):
  - Polynomial x16+x15+x2+1, bits processed LSB first, register initialised to 16'hFFFF at command accept.
  - The value sent is the ones' complement: low byte in CRC_LO, high byte in CRC_HI.
  - A zero-length packet sends 8'h00, 8'h00.
- byte_done or eop_done outside the matching WAIT state is ignored. Commands arriving while not in IDLE are ignored and do not set tx_error.
- buffer_occupancy is sampled only at accept. The FIFO is popped exactly length times per data packet.

## Timing
- Reset values:
  - tx_byte 8'h00; load_byte, get_tx_packet_data, send_eop, tx_transfer_active, tx_error all 0.
  - State IDLE, CRC register 16'hFFFF.
- Reset mid-packet aborts immediately. No EOP is requested and no further pops occur.
- Command sampled at edge N:
  - tx_transfer_active = 1 from N+1.
  - load_byte with SYNC at N+1.
- byte_done at edge M causes the next load_byte (or send_eop) at M+1.
- byte_done arriving during a load cycle is ignored; the serializer must not assert it that early.
- eop_done at edge K: tx_transfer_active = 0 and state IDLE at K+1. A new command is accepted at K+1 at the earliest.
- tx_error is set in the cycle after the bad command. It holds until the next valid command is accepted or until reset.

## Test plan
- ACK command, serializer returns byte_done 8 cycles after each load:
  - tx_byte sequence 8'h01, 8'hD2, then send_eop.
  - No pops; tx_transfer_active drops 1 cycle after eop_done.
- DATA1 with buffer_occupancy 0:
  - Bytes 8'h01, 8'h4B, 8'h00, 8'h00, then EOP.
  - get_tx_packet_data never asserted.
- DATA0 with FIFO {8'hFF, 8'hAA}:
  - Bytes 8'h01, 8'hC3, 8'hFF, 8'hAA, then two CRC bytes.
  - The CRC bytes match the bench bitwise CRC16 model.
  - Exactly 2 pops, each coincident with its load_byte.
- DATA0 with a full 64-byte FIFO of incrementing values:
  - 64 pops, 68 loads, CRC matches the model.
  - A NAK command issued mid-packet is ignored.
- Error cases:
  - tx_packet = 4'd9 → tx_error = 1, no load_byte.
  - DATA0 with buffer_occupancy 65 → tx_error = 1.
  - A subsequent valid NAK clears tx_error and transmits 8'h01, 8'h5A.
- n_rst low during DATA_WAIT:
  - All outputs return to reset values asynchronously, with no send_eop.
  - After release, an ACK command transmits normally.
